mult_div_unit: RTL and testbench

Multiply/divide responder in the E stage of the pipelined MIPS core; executes `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` and holds the HI/LO registers. The instruction decoder raises its multiply/divide stall flag for every HI/LO-class instruction. This block answers that flag with `md_busy`, and hazard control combines the two to hold the D stage. Multi-cycle latency is modelled with a down-counter; results commit atomically at the end of the busy window.

---
 rtl/mult_div_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multiply/divide responder for the E stage. Executes mult, multu, div, divu,
// mthi and mtlo, and owns the HI/LO registers. Multi-cycle operations are
// timed by a down-counter, and their results commit to HI/LO together on the
// last busy cycle.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-low reset
//   start    in   one-cycle issue strobe
//   md_op    in   3-bit op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                 5 mthi, 6 mtlo, 7 reserved (none)
//   A        in   rs operand / dividend / mt* source
//   B        in   rt operand / divisor
//   flush    in   kill of the E-stage instruction (blocks accept only)
//   busy     out  registered, high while an operation is in flight
//   md_busy  out  combinational stall request to hazard control
//   HI       out  registered HI
//   LO       out  registered LO
//
// Build option:
//   MD_DIVZERO_DEFINED_EN  when defined, div/divu by zero commit
//                          LO = 0xFFFFFFFF and HI = dividend. When undefined,
//                          HI/LO are left unchanged. Latency is the same in
//                          both builds.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        md_busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic [2:0]         op_r, op_next_s;
    logic [31:0]        a_r, a_next_s;
    logic [31:0]        b_r, b_next_s;
    logic [31:0]        hi_r, hi_next_s;
    logic [31:0]        lo_r, lo_next_s;
    logic               busy_r;
    logic               accept_s;
    logic               long_op_s;

    // 64-bit product; operands are sign- or zero-extended before multiplying.
    function automatic logic [63:0] mult_64(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // the quotient truncates toward zero and the remainder follows the
    // dividend's sign; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
    // A zero divisor is replaced by 1 here; callers filter that case.
    function automatic logic [63:0] div_64(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end else begin
            mag_b = mag_b;
        end
        q = mag_a / mag_b;
        r = mag_a % mag_b;
        return {(neg_a ? (~r + 32'd1) : r), ((neg_a ^ neg_b) ? (~q + 32'd1) : q)};
    endfunction

    assign accept_s  = start & ~flush & ~busy_r & (md_op != 3'd0) & (md_op != 3'd7);
    assign long_op_s = (md_op == OP_MULT) | (md_op == OP_MULTU) |
                       (md_op == OP_DIV)  | (md_op == OP_DIVU);

    assign busy    = busy_r;
    assign md_busy = busy_r | (start & ~flush & long_op_s);
    assign HI      = hi_r;
    assign LO      = lo_r;

    // Next-state, operand latch, counter and HI/LO update.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        op_next_s    = op_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        hi_next_s    = hi_r;
        lo_next_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            op_next_s    = md_op;
                            a_next_s     = A;
                            b_next_s     = B;
                            cnt_next_s   = CNT_W'(MULT_CYCLES);
                            state_next_s = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_next_s    = md_op;
                            a_next_s     = A;
                            b_next_s     = B;
                            cnt_next_s   = CNT_W'(DIV_CYCLES);
                            state_next_s = ST_RUN;
                        end
                        OP_MTHI: hi_next_s = A;
                        OP_MTLO: lo_next_s = A;
                        default: state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_W'(1)) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = ST_IDLE;
                    case (op_r)
                        OP_MULT:  {hi_next_s, lo_next_s} = mult_64(1'b1, a_r, b_r);
                        OP_MULTU: {hi_next_s, lo_next_s} = mult_64(1'b0, a_r, b_r);
                        OP_DIV, OP_DIVU: begin
                            if (b_r == 32'd0) begin
`ifdef MD_DIVZERO_DEFINED_EN
                                hi_next_s = a_r;
                                lo_next_s = 32'hFFFF_FFFF;
`else
                                hi_next_s = hi_r;
                                lo_next_s = lo_r;
`endif
                            end else begin
                                {hi_next_s, lo_next_s} = div_64(op_r == OP_DIV, a_r, b_r);
                            end
                        end
                        default: begin
                            hi_next_s = hi_r;
                            lo_next_s = lo_r;
                        end
                    endcase
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            cnt_r   <= cnt_next_s;
            op_r    <= op_next_s;
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            hi_r    <= hi_next_s;
            lo_r    <= lo_next_s;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        md_busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int passes = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .A       (A),
        .B       (B),
        .flush   (flush),
        .busy    (busy),
        .md_busy (md_busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic set_vec(input int i, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi,
                           input logic [31:0] lo, input int cyc);
        vecs[i].op  = op;
        vecs[i].a   = a;
        vecs[i].b   = b;
        vecs[i].hi  = hi;
        vecs[i].lo  = lo;
        vecs[i].cyc = cyc;
    endtask

    // Called at a negedge: drive one issue, check md_busy, pass edge T.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_mdb, input string name);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        #1;
        check({name, " md_busy@T"}, {31'd0, md_busy}, {31'd0, exp_mdb});
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
    endtask

    // Issue, verify busy for cyc cycles, then busy low and HI/LO at T+cyc+1.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cyc, input logic [31:0] ehi, input logic [31:0] elo,
                          input string name);
        issue(op, a, b, (op >= 3'd1) && (op <= 3'd4), name);
        for (int k = 1; k <= cyc; k++) begin
            @(negedge clk);
            check({name, " busy"}, {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check({name, " busy end"}, {31'd0, busy}, 32'd0);
        check({name, " HI"}, HI, ehi);
        check({name, " LO"}, LO, elo);
    endtask

    initial begin
        logic [31:0] hz;
        logic [31:0] lz;
        logic [31:0] hz2;
        logic [31:0] lz2;

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;

`ifdef MD_DIVZERO_DEFINED_EN
        hz  = 32'd5;
        lz  = 32'hFFFF_FFFF;
        hz2 = 32'd9;
        lz2 = 32'hFFFF_FFFF;
`else
        hz  = 32'h11;
        lz  = 32'h22;
        hz2 = 32'h11;
        lz2 = 32'h22;
`endif
        set_vec(0,  3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        set_vec(1,  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);
        set_vec(2,  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        set_vec(3,  3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        set_vec(4,  3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10);
        set_vec(5,  3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10);
        set_vec(6,  3'd4, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 10);
        set_vec(7,  3'd5, 32'h11,        32'd0,         32'h11,        32'h0FFF_FFFF, 0);
        set_vec(8,  3'd6, 32'h22,        32'd0,         32'h11,        32'h22,        0);
        set_vec(9,  3'd3, 32'd5,         32'd0,         hz,            lz,            10);
        set_vec(10, 3'd7, 32'h55,        32'd1,         hz,            lz,            0);
        set_vec(11, 3'd4, 32'd9,         32'd0,         hz2,           lz2,           10);
        set_vec(12, 3'd0, 32'h66,        32'd1,         hz2,           lz2,           0);
        set_vec(13, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset md_busy", {31'd0, md_busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table: each op issues in the same cycle the previous one ends.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i));
        end

        // Flushed mult is not accepted, then mtlo lands next cycle.
        flush = 1'b1;
        issue(3'd1, 32'd3, 32'd3, 1'b0, "flush");
        flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush HI", HI, 32'd0);
        check("flush LO", LO, 32'h8000_0000);
        run_op(3'd6, 32'hDEAD_BEEF, 32'd0, 0, 32'd0, 32'hDEAD_BEEF, "mtlo");

        // mthi issued mid-divide is ignored; divide timing is undisturbed.
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "collide");
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("collide busy", {31'd0, busy}, 32'd1);
            if (k == 3) begin
                start = 1'b1;
                md_op = 3'd5;
                A     = 32'h99;
                #1;
                check("collide md_busy", {31'd0, md_busy}, 32'd1);
                @(posedge clk);
                #1;
                start = 1'b0;
                md_op = 3'd0;
            end
        end
        @(negedge clk);
        check("collide busy end", {31'd0, busy}, 32'd0);
        check("collide HI", HI, 32'd0);
        check("collide LO", LO, 32'h8000_0000);

        // Reset in the third busy cycle of a multu aborts it.
        run_op(3'd5, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'h8000_0000, "mthi pre");
        issue(3'd2, 32'd5, 32'd7, 1'b1, "rst multu");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rst busy", {31'd0, busy}, 32'd1);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst busy after", {31'd0, busy}, 32'd0);
        check("rst md_busy after", {31'd0, md_busy}, 32'd0);
        check("rst HI after", HI, 32'd0);
        check("rst LO after", LO, 32'd0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, "post-rst multu");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
